// File: rtl/game_flow_ctrl.sv
// Turn sequencing for a two-player seven-column drop game: board writes, win/tie resolution.
// Optional move timeout is built only when MOVE_TIMEOUT_EN is defined.
module game_flow_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       drop,
    input  logic [2:0] col,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic [1:0] state,
    output logic [1:0] game_status,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic       wr_player,
    output logic       clr_board,
    output logic       reject,
    output logic       timeout,
    output logic [5:0] moves
);

    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } state_t;

    typedef enum logic {
        WAIT_DROP = 1'b0,
        WAIT_CHK  = 1'b1
    } phase_t;

    state_t     state_q;
    phase_t     phase_q;
    logic [2:0] heights [0:6];
    logic [2:0] sel_h;
    logic       col_ok;
    logic       drop_ok;
    state_t     other_player;

`ifdef MOVE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_q;
    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign state = state_q;

    // A full or nonexistent column reads as height 6 so a single compare rejects both.
    always_comb begin
        col_ok = (col != 3'd7);
        sel_h  = 3'd6;
        if (col_ok)
            sel_h = heights[col];
        drop_ok      = drop && col_ok && (sel_h != 3'd6);
        other_player = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= GAME_INIT;
            phase_q     <= WAIT_DROP;
            game_status <= 2'b00;
            wr_en       <= 1'b0;
            wr_row      <= 3'd0;
            wr_col      <= 3'd0;
            wr_player   <= 1'b0;
            clr_board   <= 1'b0;
            reject      <= 1'b0;
            moves       <= 6'd0;
            for (int i = 0; i < 7; i++)
                heights[i] <= 3'd0;
`ifdef MOVE_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            wr_en     <= 1'b0;
            clr_board <= 1'b0;
            reject    <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                GAME_INIT, END_GAME: begin
                    if (start) begin
                        clr_board   <= 1'b1;
                        moves       <= 6'd0;
                        game_status <= 2'b00;
                        state_q     <= P1_TURN;
                        phase_q     <= WAIT_DROP;
                        for (int i = 0; i < 7; i++)
                            heights[i] <= 3'd0;
`ifdef MOVE_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                default: begin
                    if (phase_q == WAIT_DROP) begin
                        if (drop_ok) begin
                            wr_en        <= 1'b1;
                            wr_row       <= sel_h;
                            wr_col       <= col;
                            wr_player    <= (state_q == P2_TURN);
                            heights[col] <= sel_h + 3'd1;
                            moves        <= moves + 6'd1;
                            phase_q      <= WAIT_CHK;
                        end else begin
                            if (drop)
                                reject <= 1'b1;
`ifdef MOVE_TIMEOUT_EN
                            // Rejected drops keep the clock running against the idle player.
                            if (to_cnt == CNT_LAST) begin
                                timeout_q <= 1'b1;
                                state_q   <= other_player;
                                to_cnt    <= '0;
                            end else begin
                                to_cnt <= to_cnt + 1'b1;
                            end
`endif
                        end
                    end else if (chk_done) begin
                        if (chk_win) begin
                            state_q     <= END_GAME;
                            game_status <= (state_q == P1_TURN) ? 2'b01 : 2'b10;
                        end else if (moves == 6'd42) begin
                            state_q     <= END_GAME;
                            game_status <= 2'b11;
                        end else begin
                            state_q <= other_player;
                            phase_q <= WAIT_DROP;
`ifdef MOVE_TIMEOUT_EN
                            to_cnt  <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized and directed bench for game_flow_ctrl against a rule-level game model.
module tb_game_flow_ctrl;

`ifdef MOVE_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 500000000;
`endif

    logic       clk = 1'b0;
    logic       rst, start, drop, chk_done, chk_win;
    logic [2:0] col;
    logic [1:0] state, game_status;
    logic       wr_en, wr_player, clr_board, reject, timeout;
    logic [2:0] wr_row, wr_col;
    logic [5:0] moves;

    game_flow_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .drop(drop), .col(col),
        .chk_done(chk_done), .chk_win(chk_win), .state(state),
        .game_status(game_status), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_player(wr_player), .clr_board(clr_board),
        .reject(reject), .timeout(timeout), .moves(moves)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game model: 0 idle, 1 = player one to move, 2 = player two, 3 = over.
    int m_state, m_status, m_moves, m_idle;
    int m_h [7];
    bit m_awaiting_result;
    int e_wr_en, e_row, e_col, e_player, e_clr, e_rej, e_to;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_status = 0; m_moves = 0; m_idle = 0;
        m_awaiting_result = 0;
        foreach (m_h[i]) m_h[i] = 0;
        e_wr_en = 0; e_row = 0; e_col = 0; e_player = 0;
        e_clr = 0; e_rej = 0; e_to = 0;
    endtask

    task automatic model_step(input bit st, input bit dr, input int c, input bit cd, input bit cw);
        e_wr_en = 0; e_clr = 0; e_rej = 0; e_to = 0;
        if (m_state == 0 || m_state == 3) begin
            if (st) begin
                e_clr = 1; m_moves = 0; m_status = 0; m_state = 1;
                m_awaiting_result = 0; m_idle = 0;
                foreach (m_h[i]) m_h[i] = 0;
            end
        end else if (!m_awaiting_result) begin
            if (dr && c < 7 && m_h[c] < 6) begin
                e_wr_en = 1; e_row = m_h[c]; e_col = c; e_player = m_state - 1;
                m_h[c]++; m_moves++; m_awaiting_result = 1;
            end else begin
                if (dr) e_rej = 1;
`ifdef MOVE_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    e_to = 1; m_state = 3 - m_state; m_idle = 0;
                end
`endif
            end
        end else if (cd) begin
            if (cw) begin
                m_status = m_state; m_state = 3;
            end else if (m_moves == 42) begin
                m_status = 3; m_state = 3;
            end else begin
                m_state = 3 - m_state; m_awaiting_result = 0; m_idle = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("state", int'(state), m_state);
        check("game_status", int'(game_status), m_status);
        check("moves", int'(moves), m_moves);
        check("wr_en", int'(wr_en), e_wr_en);
        check("wr_row", int'(wr_row), e_row);
        check("wr_col", int'(wr_col), e_col);
        check("wr_player", int'(wr_player), e_player);
        check("clr_board", int'(clr_board), e_clr);
        check("reject", int'(reject), e_rej);
        check("timeout", int'(timeout), e_to);
    endtask

    task automatic step(input bit st, input bit dr, input int c, input bit cd, input bit cw);
        @(negedge clk);
        compare_all();
        start = st; drop = dr; col = 3'(c); chk_done = cd; chk_win = cw;
        model_step(st, dr, c, cd, cw);
    endtask

    // Reset lands mid-cycle to show the clear does not wait for a clock edge.
    task automatic do_reset();
        @(negedge clk);
        compare_all();
        #2;
        rst = 1'b1; start = 0; drop = 0; col = 0; chk_done = 0; chk_win = 0;
        #1;
        check("rst_async_state", int'(state), 0);
        check("rst_async_status", int'(game_status), 0);
        check("rst_async_moves", int'(moves), 0);
        check("rst_async_wr_en", int'(wr_en), 0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        model_step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; drop = 0; col = 0; chk_done = 0; chk_win = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;
        model_step(0, 0, 0, 0, 0);

        // Idle in GAME_INIT: drops and results are ignored.
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 1);

        // Opening moves on column 3.
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 3, 0, 0);
        step(0, 1, 4, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Fill column 0, then overflow and invalid-column rejects.
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0);

        // Player two wins, then a restart.
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 1, 2, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Full board with no winner, then a win on the final disc.
        for (int g = 0; g < 2; g++) begin
            step(1, 0, 0, 0, 0);
            for (int i = 0; i < 42; i++) begin
                step(0, 1, i / 6, 0, 0);
                step(0, 0, 0, 1, (g == 1 && i == 41) ? 1'b1 : 1'b0);
            end
            step(0, 1, 5, 0, 0);
            step(0, 0, 0, 1, 0);
        end

        // Idle turn, then reset while waiting for the checker.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, i, 1, 0);

        // Random play.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        compare_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000000, cycles a player may idle before forfeiting the turn; used only with MOVE_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse, begin a new game.
REQ-005 SHALL have port drop  input  1  one-cycle pulse, current player drops a disc into col.
REQ-006 SHALL have port col  input  3  column index for drop, valid 0..6.
REQ-007 SHALL have port chk_done  input  1  one-cycle pulse from win checker, result valid.
REQ-008 SHALL have port chk_win  input  1  win flag, sampled only when chk_done=1.
REQ-009 SHALL have port state  output  2  GAME_INIT=00, P1_TURN=01, P2_TURN=10, END_GAME=11.
REQ-010 SHALL have port game_status  output  2  STILL_PLAYING=00, P1_WINS=01, P2_WINS=10, TIE=11.
REQ-011 SHALL have port wr_en  output  1  one-cycle board write strobe.
REQ-012 SHALL have ports wr_row (3), wr_col (3), wr_player (1; 0=P1, 1=P2), all outputs, board write address/data, valid when wr_en=1.
REQ-013 SHALL have port clr_board  output  1  one-cycle board clear pulse.
REQ-014 SHALL have port reject  output  1  one-cycle pulse, drop refused.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse, turn forfeited.
REQ-016 SHALL have port moves  output  6  count of accepted discs, 0..42.

Function
REQ-017 SHALL keep seven 3-bit column heights (0..6) and an internal phase: WAIT_DROP or WAIT_CHK.
REQ-018 In GAME_INIT or END_GAME, start SHALL, next cycle: pulse clr_board, zero heights and moves, set game_status=00, state=P1_TURN, phase=WAIT_DROP.
REQ-019 start in P1_TURN/P2_TURN SHALL be ignored; drop in GAME_INIT/END_GAME SHALL be ignored with no reject.
REQ-020 In WAIT_DROP, drop with col<=6 and height[col]<6 SHALL be accepted: next cycle wr_en=1 for exactly one cycle, wr_row=old height[col], wr_col=col, wr_player=current player; height[col]+1, moves+1, phase=WAIT_CHK.
REQ-021 In WAIT_DROP, drop with col=7 or height[col]=6 SHALL pulse reject next cycle; no other state change; same player keeps turn.
REQ-022 In WAIT_CHK, drop SHALL be ignored with no reject; block SHALL wait indefinitely for chk_done.
REQ-023 On chk_done with chk_win=1, next cycle state=END_GAME, game_status=P1_WINS or P2_WINS per mover.
REQ-024 On chk_done with chk_win=0 and moves=42, next cycle state=END_GAME, game_status=TIE; win takes priority over tie on move 42.
REQ-025 On chk_done with chk_win=0 and moves<42, next cycle state toggles P1_TURN<->P2_TURN, phase=WAIT_DROP.
REQ-026 chk_done outside WAIT_CHK SHALL be ignored.
REQ-027 game_status SHALL remain 00 in every state except END_GAME; END_GAME SHALL hold until start.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL immediately force state=GAME_INIT, game_status=00, all pulses 0, wr_row/wr_col/wr_player=0, heights=0, moves=0, phase=WAIT_DROP, timeout counter=0, regardless of operation in progress.
REQ-030 After rst deasserts, block SHALL remain in GAME_INIT until start.

Configuration
REQ-031 With macro MOVE_TIMEOUT_EN defined, a counter SHALL clear on each entry to WAIT_DROP and count in WAIT_DROP; on reaching TIMEOUT_CYCLES-1 without accepted drop, next cycle timeout pulses, turn passes to other player, moves unchanged; rejected drops do not clear the counter.
REQ-032 Without MOVE_TIMEOUT_EN, no counter SHALL be built and timeout SHALL be tied 0.

Verification
REQ-033 rst, start, P1 drop col=3 -> clr_board pulse, state=01, then wr_en with row=0,col=3,player=0, moves=1.
REQ-034 After REQ-033 step, chk_done chk_win=0 -> state=10; P2 drop col=3 -> wr_row=1, player=1.
REQ-035 Fill col 0 to height 6, drop col=0 -> reject pulse, state unchanged; drop col=7 -> reject.
REQ-036 P2 move, chk_done chk_win=1 -> state=11, game_status=10; start -> state=01, status=00, moves=0.
REQ-037 42 moves no win -> status=11 (TIE); repeat with chk_win=1 on move 42 -> win status.
REQ-038 MOVE_TIMEOUT_EN, TIMEOUT_CYCLES=16: P1 idle 16 cycles -> timeout pulse, state=10; rst asserted during WAIT_CHK -> state=00 immediately.
